// File: rtl/logic_unit_pipe.sv
// Single-stage registered bitwise logic unit with valid/ready handshake and an
// accumulator that can stand in for the first operand.
module logic_unit_pipe #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             acc_mode,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             zero
);

   logic [WIDTH-1:0] s_q, s_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             zero_q, zero_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] result;
   logic             accept;

   assign in_ready = !reset && (!valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   // A same-cycle clear makes the accumulator read as zero for this operation.
   always_comb begin
      x = a;
      if (acc_mode) begin
         x = acc_clr ? '0 : acc_q;
      end
   end

   always_comb begin
      result = '0;
      unique case (op)
         3'b000: result = x & b;
         3'b001: result = ~(x & b);
         3'b010: result = x | b;
         3'b011: result = ~(x | b);
         3'b100: result = x ^ b;
         3'b101: result = ~(x ^ b);
         3'b110: result = ~x;
         3'b111: result = x;
         default: result = '0;
      endcase
   end

   always_comb begin
      s_d     = s_q;
      zero_d  = zero_q;
      valid_d = valid_q;
      acc_d   = acc_q;
      if (accept) begin
         s_d     = result;
         zero_d  = (result == '0);
         valid_d = 1'b1;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
      if (accept && acc_mode) begin
         acc_d = result;
      end else if (acc_clr) begin
         acc_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s_q     <= '0;
         zero_q  <= 1'b1;
         valid_q <= 1'b0;
         acc_q   <= '0;
      end else begin
         s_q     <= s_d;
         zero_q  <= zero_d;
         valid_q <= valid_d;
         acc_q   <= acc_d;
      end
   end

   assign s         = s_q;
   assign zero      = zero_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: directed scenarios plus random traffic
// checked against a behavioural model of the operation set and handshake.
module tb_logic_unit_pipe;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [2:0]   op = '0;
   logic         acc_mode = 1'b0;
   logic         acc_clr = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] s;
   logic         zero;

   int checks = 0;
   int errors = 0;

   logic [W:0] sb[$];
   logic       m_ov = 1'b0;
   logic [W-1:0] m_acc = '0;
   logic       exp_ov = 1'b0;
   logic       exp_rdy = 1'b0;

   logic [W-1:0] sweep_tbl [8];

   logic_unit_pipe #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr),
      .out_valid(out_valid), .out_ready(out_ready), .s(s), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] apply_op(input logic [2:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
      case (o)
         3'd0: return x & y;
         3'd1: return ~(x & y);
         3'd2: return x | y;
         3'd3: return ~(x | y);
         3'd4: return x ^ y;
         3'd5: return ~(x ^ y);
         3'd6: return ~x;
         default: return x;
      endcase
   endfunction

   // Drive one cycle of inputs just after the edge and advance the model.
   task automatic cyc(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [2:0] iop, input logic am, input logic clr,
                      input logic ordy, input logic rst);
      logic [W-1:0] x;
      logic [W-1:0] r;
      @(posedge clk);
      #2;
      reset = rst; in_valid = iv; a = ia; b = ib; op = iop;
      acc_mode = am; acc_clr = clr; out_ready = ordy;
      exp_ov  = m_ov;
      exp_rdy = !rst && (!m_ov || ordy);
      if (rst) begin
         m_ov = 1'b0;
         m_acc = '0;
         sb.delete();
      end else if (iv && exp_rdy) begin
         x = am ? (clr ? '0 : m_acc) : ia;
         r = apply_op(iop, x, ib);
         sb.push_back({r, (r == '0)});
         m_ov = 1'b1;
         if (am) m_acc = r;
         else if (clr) m_acc = '0;
      end else begin
         if (ordy) m_ov = 1'b0;
         if (clr) m_acc = '0;
      end
   endtask

   task automatic idle(input logic ordy);
      cyc(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, ordy, 1'b0);
   endtask

   // Monitor: checks handshake each cycle and pops on every consumed result.
   initial begin
      logic [W:0] e;
      forever begin
         @(negedge clk);
         if (reset) begin
            check("in_ready_in_reset", in_ready, 0);
         end else begin
            check("out_valid", out_valid, exp_ov);
            check("in_ready", in_ready, exp_rdy);
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_result", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check("result_s", s, e[W:1]);
                  check("result_zero", zero, e[0]);
               end
            end
         end
      end
   end

   initial begin
      sweep_tbl = '{8'h81, 8'h7E, 8'hE7, 8'h18, 8'h66, 8'h99, 8'h3C, 8'hC3};

      cyc(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b1, 8'hFF, 8'hFF, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
      idle(1'b1);
      @(negedge clk);
      check("reset_s", s, 8'h00);
      check("reset_zero", zero, 1);
      check("reset_valid", out_valid, 0);

      // Op sweep
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) cyc(1'b1, 8'hC3, 8'hA5, 3'(i), 1'b0, 1'b0, 1'b1, 1'b0);
         else idle(1'b1);
         @(negedge clk);
         if (i > 0) begin
            check("sweep_s", s, sweep_tbl[i-1]);
            check("sweep_zero", zero, 0);
         end
      end

      // Zero flag
      cyc(1'b1, 8'hF0, 8'h0F, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 8'hF0, 8'h0F, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check("zflag_and_s", s, 8'h00);
      check("zflag_and_z", zero, 1);
      idle(1'b1);
      @(negedge clk);
      check("zflag_or_s", s, 8'hFF);
      check("zflag_or_z", zero, 0);

      // Backpressure
      cyc(1'b1, 8'h55, 8'hFF, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, W'($urandom), W'($urandom), 3'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
         @(negedge clk);
         check("stall_s", s, 8'hAA);
         check("stall_ready", in_ready, 0);
      end
      cyc(1'b1, 8'h12, 8'h34, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      @(negedge clk);
      check("after_stall_s", s, 8'h36);

      // Accumulator chain from acc=0
      cyc(1'b1, 8'h77, 8'h00, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 8'h77, 8'h0F, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check("chain_pass", s, 8'h00);
      cyc(1'b1, 8'h77, 8'hFF, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check("chain_xnor", s, 8'hF0);
      cyc(1'b1, 8'h77, 8'h33, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check("chain_xor", s, 8'h0F);
      cyc(1'b1, 8'h00, 8'h00, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check("chain_clr_or", s, 8'h33);
      idle(1'b1);
      @(negedge clk);
      check("chain_acc", s, 8'h33);

      // Back-to-back throughput
      for (int i = 0; i < 8; i++)
         cyc(1'b1, W'($urandom), W'($urandom), 3'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
      idle(1'b1);

      // Mid-stall reset
      cyc(1'b1, 8'h00, 8'hF0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 8'h55, 8'hFF, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(1'b0);
      @(negedge clk);
      check("pre_reset_s", s, 8'hAA);
      cyc(1'b1, 8'h11, 8'h22, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(1'b0);
      @(negedge clk);
      check("mid_reset_valid", out_valid, 0);
      check("mid_reset_s", s, 8'h00);
      check("mid_reset_zero", zero, 1);
      cyc(1'b1, 8'hAB, 8'h00, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      @(negedge clk);
      check("post_reset_acc", s, 8'h00);
      check("post_reset_zero", zero, 1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 3'($urandom),
             1'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 49) == 0));
      end

      for (int i = 0; i < 3; i++) idle(1'b1);
      @(negedge clk);
      check("drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, giving the operand and result width in bits (WIDTH >= 1).
REQ-002 The block SHALL have these ports:
  - clk  input  1  sole clock; all state updates on its rising edge.
  - reset  input  1  synchronous, active-high reset.
  - in_valid  input  1  an operand set is presented.
  - in_ready  output  1  the block can accept an operand set this cycle.
  - a  input  WIDTH  first operand.
  - b  input  WIDTH  second operand.
  - op  input  3  operation select.
  - acc_mode  input  1  use the accumulator in place of a.
  - acc_clr  input  1  clear the accumulator.
  - out_valid  output  1  s and zero hold a result.
  - out_ready  input  1  the consumer takes the result this cycle.
  - s  output  WIDTH  registered result.
  - zero  output  1  registered flag; 1 when s is all zeros.

Function
REQ-003 The op encoding SHALL be: 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110 NOT x, 111 pass x, where x is the effective first operand.
REQ-004 All ops SHALL be bitwise over WIDTH bits, with no carries and no width growth.
REQ-005 The effective first operand x SHALL be acc when acc_mode=1, and a otherwise.
REQ-006 An internal WIDTH-bit register acc SHALL exist.
REQ-007 Acceptance SHALL occur exactly in cycles where in_valid=1 and in_ready=1.
REQ-008 in_ready SHALL be combinational: in_ready = !out_valid || out_ready.
REQ-009 On acceptance, the result SHALL be registered into s, with zero = (result == 0) and out_valid=1, at the next edge (latency 1 cycle).
REQ-010 On acceptance with acc_mode=1, acc SHALL load the result at the same edge.
REQ-011 On acceptance with acc_mode=0, acc SHALL be unchanged (unless acc_clr=1).
REQ-012 While out_valid=1 and out_ready=0, s, zero and out_valid SHALL hold stable.
REQ-013 While out_valid=1 and out_ready=0, in_ready SHALL be 0, and a, b, op and acc_mode SHALL be ignored.
REQ-014 When out_valid=1, out_ready=1 and no acceptance occurs, out_valid SHALL go to 0 at the next edge.
REQ-015 When out_valid=1, out_ready=1 and in_valid=1 in the same cycle, the old result SHALL be consumed and the new result loaded in the same edge, with no bubble, giving full throughput of 1 result/cycle.
REQ-016 acc_clr=1 without acceptance SHALL set acc to 0 at the next edge, whether or not a result is stalled.
REQ-017 When acc_clr=1 and an acceptance with acc_mode=1 occur in the same cycle, x SHALL be taken as 0 and acc SHALL load the resulting value.
REQ-018 When acc_clr=1 and an acceptance with acc_mode=0 occur in the same cycle, the result SHALL use a, and acc SHALL become 0.
REQ-019 s and zero SHALL change only on acceptance or reset.
REQ-020 When out_valid=0, s and zero SHALL keep their last values; consumers must qualify them with out_valid.
REQ-021 The block SHALL contain no combinational path from a, b, op or acc_mode to s or zero.
REQ-022 The only combinational path to any output SHALL be out_ready to in_ready.

Reset
REQ-023 With reset=1 at a rising edge, the following SHALL take effect at that edge regardless of other inputs: out_valid=0, s=0, zero=1, acc=0.
REQ-024 While reset=1, in_ready SHALL be forced to 0.
REQ-025 Transactions presented during reset SHALL be dropped.
REQ-026 A result stalled when reset asserts SHALL be discarded.
REQ-027 The first acceptance SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-028 Op sweep: WIDTH=8, a=8'hC3, b=8'hA5, op=0..7, out_ready=1 -> s equals C3&A5=81, 7E, E7, 18, 66, 99, 3C, C3 respectively, each one cycle after acceptance; zero=0 throughout.
REQ-029 Zero flag: a=8'hF0, b=8'h0F, op=000 -> s=00 and zero=1; then op=010 -> s=FF and zero=0.
REQ-030 Backpressure: accept a=55, b=FF, op=100, hold out_ready=0 for 3 cycles while in_valid=1 with new data -> s stays AA, in_ready=0, and no second acceptance; raise out_ready -> next result is loaded on that edge.
REQ-031 Accumulator chain, starting from acc=0:
  - acc_mode=1, op=111 pass: s=00.
  - Then op=101 XNOR with b=0F: s=F0, acc=F0.
  - Then op=100 XOR with b=FF: s=0F, acc=0F.
  - Then acc_clr=1 with acc_mode=1, op=010, b=33: s=33, acc=33.
REQ-032 Back-to-back throughput: out_ready=1 and in_valid=1 for 8 consecutive cycles -> 8 results on 8 consecutive cycles, out_valid continuously 1, and no drops.
REQ-033 Mid-stall reset: stalled result s=AA with acc=F0, then reset pulse -> out_valid=0, s=00, zero=1, acc=00; a subsequent pass op with acc_mode=1 gives s=00.
